// File: rtl/eth_frame_rx.sv
// rtl/eth_frame_rx.sv - serial preamble/SFD hunting frame receiver with a held-frame buffer and host handshake
// Optional destination MAC filtering is enabled by defining ETH_RX_MAC_FILTER_EN.
module eth_frame_rx #(
  parameter int          FRAME_MAX = 128,
  parameter int          MIN_LEN   = 8,
  parameter logic [7:0]  PRE_BYTE  = 8'h55,
  parameter logic [7:0]  SFD_BYTE  = 8'hD5,
  parameter logic [47:0] MY_MAC    = 48'h02_00_00_00_00_01,
  localparam int         ADDR_W    = $clog2(FRAME_MAX)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              Rx,
  input  logic              Rx_valid,
  output logic              frame_ready,
  output logic [ADDR_W:0]   frame_len,
  output logic              frame_err,
  input  logic              frame_ack,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic [7:0]        drop_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_HUNT, S_DATA, S_END} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [15:0]       r_sreg;
  logic [2:0]        r_bitcnt;
  logic [7:0]        r_byte;
  logic [ADDR_W:0]   r_wr_ptr;
  logic              r_ovf;
  logic              r_busy;
  logic [7:0]        r_buf [FRAME_MAX];

  logic [15:0]       w_sreg_shift;
  logic [7:0]        w_byte_next;
  logic              w_sfd_hit;
  logic              w_bit_in;
  logic              w_byte_done;
  logic              w_wr_en;
  logic              w_end;
  logic              w_mac_bad;
  logic              w_frame_bad;

  assign w_sreg_shift = {r_sreg[14:0], Rx};
  assign w_byte_next  = {r_byte[6:0], Rx};

`ifdef ETH_RX_MAC_FILTER_EN
  logic [47:0] r_dest;
  assign w_mac_bad = (r_wr_ptr < (ADDR_W+1)'(6)) || ((r_dest != MY_MAC) && (r_dest != '1));
`else
  logic w_unused_mac;
  assign w_unused_mac = ^MY_MAC;
  assign w_mac_bad    = 1'b0;
`endif

  // A frame that started while another was held (r_busy) never wrote the buffer, so it must be dropped.
  assign w_frame_bad = r_busy || frame_ready || (r_wr_ptr < (ADDR_W+1)'(MIN_LEN)) || w_mac_bad;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (enable && Rx_valid) w_state_next = S_HUNT;
      S_HUNT: if (enable) begin
        if (!Rx_valid)                                 w_state_next = S_IDLE;
        else if (w_sreg_shift == {PRE_BYTE, SFD_BYTE}) w_state_next = S_DATA;
      end
      S_DATA: if (enable && !Rx_valid) w_state_next = S_END;
      S_END:  if (enable) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_sfd_hit   = (r_state == S_HUNT) && enable && Rx_valid && (w_sreg_shift == {PRE_BYTE, SFD_BYTE});
    w_bit_in    = (r_state == S_DATA) && enable && Rx_valid;
    w_byte_done = w_bit_in && (r_bitcnt == 3'd7);
    w_wr_en     = w_byte_done && !r_busy && !r_wr_ptr[ADDR_W] && !rst;
    w_end       = (r_state == S_END) && enable;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sreg      <= '0;
      r_bitcnt    <= '0;
      r_byte      <= '0;
      r_wr_ptr    <= '0;
      r_ovf       <= 1'b0;
      r_busy      <= 1'b0;
      frame_ready <= 1'b0;
      frame_len   <= '0;
      frame_err   <= 1'b0;
      drop_cnt    <= '0;
`ifdef ETH_RX_MAC_FILTER_EN
      r_dest      <= '0;
`endif
    end else begin
      if (r_state == S_IDLE)                r_sreg <= (enable && Rx_valid) ? {15'b0, Rx} : '0;
      else if (r_state == S_HUNT && enable) r_sreg <= w_sreg_shift;

      if (w_sfd_hit) begin
        r_bitcnt <= '0;
        r_wr_ptr <= '0;
        r_ovf    <= 1'b0;
        r_busy   <= frame_ready;
`ifdef ETH_RX_MAC_FILTER_EN
        r_dest   <= '0;
`endif
      end

      if (w_bit_in) begin
        r_byte   <= w_byte_next;
        r_bitcnt <= r_bitcnt + 3'd1;
      end

      if (w_byte_done) begin
        if (r_wr_ptr[ADDR_W]) r_ovf    <= 1'b1;
        else                  r_wr_ptr <= r_wr_ptr + (ADDR_W+1)'(1);
`ifdef ETH_RX_MAC_FILTER_EN
        if (r_wr_ptr < (ADDR_W+1)'(6)) r_dest <= {r_dest[39:0], w_byte_next};
`endif
      end

      if (frame_ready && frame_ack) frame_ready <= 1'b0;

      if (w_end && !w_frame_bad) begin
        frame_ready <= 1'b1;
        frame_len   <= r_wr_ptr;
        frame_err   <= r_ovf;
      end

      if (w_end && w_frame_bad && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_buf[r_wr_ptr[ADDR_W-1:0]] <= w_byte_next;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data <= 8'h00;
    else     rd_data <= r_buf[rd_addr];
  end

endmodule
